// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// A one-cycle BOOT state after reset holds the PC while IF/ID is a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] im_ins,
    output logic [6:0]  im_addr,
    output logic [31:0] pc,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        misalign,
    output logic [31:0] fetch_cnt
);

    typedef enum logic {BOOT, RUN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] idpc_q, idpc_d;
    logic [31:0] idpc4_q, idpc4_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        ins_d   = ins_q;
        idpc_d  = idpc_q;
        idpc4_d = idpc4_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        // Redirect wins in either state; BOOT otherwise just inserts a bubble.
        if (redirect) begin
            state_d = RUN;
            pc_d    = {redirect_pc[31:2], 2'b00};
            mis_d   = |redirect_pc[1:0];
            vld_d   = 1'b0;
            ins_d   = NOP_INS;
            idpc_d  = 32'd0;
            idpc4_d = 32'd0;
        end else if (state_q == BOOT) begin
            state_d = RUN;
            vld_d   = 1'b0;
            ins_d   = NOP_INS;
            idpc_d  = 32'd0;
            idpc4_d = 32'd0;
        end else if (stall) begin
            // hold everything; a concurrent flush is dropped
        end else if (flush) begin
            pc_d    = pc_inc;
            vld_d   = 1'b0;
            ins_d   = NOP_INS;
            idpc_d  = 32'd0;
            idpc4_d = 32'd0;
        end else begin
            pc_d    = pc_inc;
            vld_d   = 1'b1;
            ins_d   = im_ins;
            idpc_d  = pc_q;
            idpc4_d = pc_inc;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            ins_q   <= NOP_INS;
            idpc_q  <= 32'd0;
            idpc4_q <= 32'd0;
            cnt_q   <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            ins_q   <= ins_d;
            idpc_q  <= idpc_d;
            idpc4_q <= idpc4_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign im_addr   = pc_q[8:2];
    assign pc        = pc_q;
    assign id_valid  = vld_q;
    assign id_ins    = ins_q;
    assign id_pc     = idpc_q;
    assign id_pc4    = idpc4_q;
    assign misalign  = mis_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns 0xC000_0000 | pc.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect;
    logic [31:0] redirect_pc, im_ins;
    logic [6:0]  im_addr;
    logic [31:0] pc, id_ins, id_pc, id_pc4, fetch_cnt;
    logic        id_valid, misalign;
    int          errs = 0;
    int          chks = 0;

    always #5 clk = ~clk;

    assign im_ins = 32'hC000_0000 | pc;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INS(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .im_ins(im_ins),
        .im_addr(im_addr), .pc(pc), .id_valid(id_valid), .id_ins(id_ins),
        .id_pc(id_pc), .id_pc4(id_pc4), .misalign(misalign), .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic f,
                         input logic rd, input logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        step();
        chk("rst_pc", pc, 0);
        chk("rst_vld", {31'd0, id_valid}, 0);
        chk("rst_ins", id_ins, NOP);
        chk("rst_cnt", fetch_cnt, 0);
        chk("rst_mis", {31'd0, misalign}, 0);

        drive(0, 0, 0, 0, 0);
        step();
        chk("boot_pc", pc, 0);
        chk("boot_vld", {31'd0, id_valid}, 0);
        chk("boot_cnt", fetch_cnt, 0);
        step();
        chk("c2_idpc", id_pc, 0);
        chk("c2_vld", {31'd0, id_valid}, 1);
        chk("c2_ins", id_ins, 32'hC000_0000);
        chk("c2_pc", pc, 4);
        step();
        chk("c3_idpc", id_pc, 4);
        chk("c3_idpc4", id_pc4, 8);
        chk("c3_pc", pc, 8);
        chk("c3_cnt", fetch_cnt, 2);
        chk("c3_ins", id_ins, 32'hC000_0004);

        step(); step();
        chk("pre_stall_pc", pc, 32'h10);
        chk("pre_stall_cnt", fetch_cnt, 4);
        drive(0, 1, 0, 0, 0);
        step();
        chk("st1_pc", pc, 32'h10);
        chk("st1_idpc", id_pc, 32'hC);
        drive(0, 1, 1, 0, 0);
        step();
        chk("st2_pc", pc, 32'h10);
        chk("st2_vld", {31'd0, id_valid}, 1);
        chk("st2_idpc", id_pc, 32'hC);
        chk("st2_cnt", fetch_cnt, 4);
        drive(0, 0, 0, 0, 0);
        step();
        chk("rel_pc", pc, 32'h14);
        chk("rel_idpc", id_pc, 32'h10);
        chk("rel_cnt", fetch_cnt, 5);

        drive(0, 0, 1, 0, 0);
        step();
        chk("fl_pc", pc, 32'h18);
        chk("fl_vld", {31'd0, id_valid}, 0);
        chk("fl_ins", id_ins, NOP);
        chk("fl_idpc", id_pc, 0);
        chk("fl_idpc4", id_pc4, 0);
        chk("fl_cnt", fetch_cnt, 5);
        drive(0, 0, 0, 0, 0);
        step();
        chk("afl_idpc", id_pc, 32'h18);
        chk("afl_cnt", fetch_cnt, 6);
        step();
        chk("pre_rd_pc", pc, 32'h20);

        drive(0, 1, 1, 1, 32'h40);
        step();
        chk("rd_pc", pc, 32'h40);
        chk("rd_vld", {31'd0, id_valid}, 0);
        chk("rd_ins", id_ins, NOP);
        chk("rd_cnt", fetch_cnt, 7);
        chk("rd_mis", {31'd0, misalign}, 0);
        drive(0, 0, 0, 0, 0);
        step();
        chk("ard_idpc", id_pc, 32'h40);
        chk("ard_pc", pc, 32'h44);
        chk("ard_cnt", fetch_cnt, 8);

        drive(0, 0, 0, 1, 32'h46);
        step();
        chk("mis_pc", pc, 32'h44);
        chk("mis_hi", {31'd0, misalign}, 1);
        drive(0, 0, 0, 0, 0);
        step();
        chk("mis_lo", {31'd0, misalign}, 0);
        chk("amis_idpc", id_pc, 32'h44);
        chk("amis_cnt", fetch_cnt, 9);

        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_ia1", {25'd0, im_addr}, 32'h7F);
        drive(0, 0, 0, 0, 0);
        step();
        chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_idpc4", id_pc4, 0);
        chk("wrap_pc0", pc, 0);
        chk("wrap_ia0", {25'd0, im_addr}, 0);
        chk("wrap_cnt", fetch_cnt, 10);

        drive(0, 0, 0, 1, 32'h30);
        step();
        drive(0, 1, 0, 0, 0);
        step();
        chk("st30_pc", pc, 32'h30);
        drive(1, 1, 0, 1, 32'h88);
        step();
        chk("rs_pc", pc, 0);
        chk("rs_cnt", fetch_cnt, 0);
        chk("rs_vld", {31'd0, id_valid}, 0);
        chk("rs_mis", {31'd0, misalign}, 0);
        drive(0, 0, 0, 0, 0);
        step();
        chk("rs_boot_pc", pc, 0);
        chk("rs_boot_vld", {31'd0, id_valid}, 0);
        step();
        chk("rs_run_pc", pc, 4);
        chk("rs_run_idpc", id_pc, 0);
        chk("rs_run_cnt", fetch_cnt, 1);

        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 32'h102);
        step();
        chk("brd_pc", pc, 32'h100);
        chk("brd_mis", {31'd0, misalign}, 1);
        chk("brd_vld", {31'd0, id_valid}, 0);
        drive(0, 0, 0, 0, 0);
        step();
        chk("abrd_pc", pc, 32'h104);
        chk("abrd_idpc", id_pc, 32'h100);
        chk("abrd_cnt", fetch_cnt, 1);
        chk("abrd_ia", {25'd0, im_addr}, 32'h41);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INS, default 32'h0000_0000, instruction word placed in IF/ID on a bubble.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 stall  input  1  hazard hold; freezes PC and IF/ID.
REQ-007 flush  input  1  squashes IF/ID contents into a bubble.
REQ-008 redirect  input  1  taken branch/jump/jr/jal from a later stage.
REQ-009 redirect_pc  input  32  target PC for redirect.
REQ-010 im_ins  input  32  instruction word from combinational instruction memory.
REQ-011 im_addr  output  7  instruction memory word address.
REQ-012 pc  output  32  current fetch PC.
REQ-013 id_valid  output  1  IF/ID holds a real instruction.
REQ-014 id_ins  output  32  IF/ID instruction.
REQ-015 id_pc  output  32  IF/ID instruction address.
REQ-016 id_pc4  output  32  IF/ID address + 4 (link value for jal/jalr).
REQ-017 misalign  output  1  one-cycle pulse: redirect_pc[1:0] nonzero.
REQ-018 fetch_cnt  output  32  count of instructions captured into IF/ID.

Function
REQ-019 im_addr SHALL equal pc[8:2], combinationally.
REQ-020 The FSM SHALL have two states, BOOT and RUN; reset enters BOOT.
REQ-021 BOOT SHALL last exactly one cycle when redirect is low: pc held, IF/ID bubble, fetch_cnt unchanged, next state RUN.
REQ-022 Redirect in BOOT SHALL load the redirect target per REQ-025 and go to RUN.
REQ-023 In RUN, per-edge priority SHALL be: rst > redirect > stall > flush > normal advance.
REQ-024 Normal advance: pc <= pc+4; IF/ID <= {valid=1, im_ins, pc, pc+4}; fetch_cnt <= fetch_cnt+1.
REQ-025 Redirect: pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble; fetch_cnt unchanged; overrides stall and flush.
REQ-026 Stall (no redirect): pc, IF/ID, fetch_cnt held; a concurrent flush is ignored.
REQ-027 Flush (no redirect, no stall): pc <= pc+4; IF/ID <= bubble; fetch_cnt unchanged.
REQ-028 Bubble SHALL mean id_valid=0, id_ins=NOP_INS, id_pc=0, id_pc4=0.
REQ-029 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 fetch_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-031 misalign SHALL be registered: high the cycle after an accepted redirect whose redirect_pc[1:0] != 0, else low.
REQ-032 The block SHALL contain no combinational path from any input to any output except im_ins-independent im_addr from pc.

Reset
REQ-033 rst high at an edge SHALL set pc=RESET_PC, IF/ID=bubble, fetch_cnt=0, misalign=0, state=BOOT, regardless of all other inputs.
REQ-034 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation entirely.

Verification
REQ-035 Reset then 3 free-running cycles, im_ins=ins_at(pc) -> cycle1 BOOT: pc=0, id_valid=0; cycle2: id_pc=0; cycle3: id_pc=4, id_pc4=8, pc=8, fetch_cnt=2.
REQ-036 In RUN at pc=0x10, stall high 2 cycles -> pc stays 0x10, IF/ID and fetch_cnt unchanged; release -> pc=0x14, id_pc=0x10.
REQ-037 At pc=0x20, redirect=1, redirect_pc=0x40, stall=1, flush=1 same cycle -> pc=0x40, id_valid=0, id_ins=NOP_INS, fetch_cnt unchanged; next edge id_pc=0x40.
REQ-038 redirect_pc=0x0000_0046 -> pc=0x44, misalign=1 for exactly one cycle.
REQ-039 Redirect to 0xFFFF_FFFC then advance -> id_pc=0xFFFF_FFFC, id_pc4=0, pc=0; im_addr=7'h7F then 7'h00.
REQ-040 rst asserted during a stall with pc=0x30 -> next edge pc=RESET_PC, fetch_cnt=0, id_valid=0, state BOOT.
